rf_scoreboard: RTL and testbench

- Hazard scoreboard sitting directly downstream of the register decode stage, in parallel with the register-file read.
- Consumes the decoded read indices (rs1/rs2/rs3) and write indices/enables (ws1/ws2, we1/we2).
- Tracks in-flight register writes with a per-register pending counter and stalls decode while any used source, or an over-subscribed destination, is pending.
- Writeback retires pending writes; a pipeline flush clears all tracking.

---
 rtl/rf_scoreboard.sv | 185 ++++++++++++++++++
 tb/tb_rf_scoreboard.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rf_scoreboard.sv
// rf_scoreboard
// -------------
// Register hazard scoreboard that sits beside the register-file read, just
// after register decode. It keeps one pending-write counter per architectural
// register. It stalls decode in two cases: when a used source register still
// has an outstanding write, or when issuing would overflow a destination
// counter. Writeback retires pending writes, and a flush clears all tracking.
//
// Ports
//   clk           clock; all state changes on the rising edge
//   rst_b         synchronous active-low reset; overrides every other input
//   dec_valid     an instruction is present in decode
//   dec_ready     decode may issue this cycle (combinational, 0 = stall)
//   rf_rs1..3     source register indices
//   rs_used       per-source use enables {rs3, rs2, rs1}
//   rf_ws1/2      destination register indices
//   rf_we1/2      destination write enables
//   wb_we1/2      writeback retires one write on port 1/2
//   wb_ws1/2      register retired on port 1/2
//   flush         squash: clear all counters and drop the same-cycle issue
//   pending_mask  registered view of the counters, bit r = (count[r] != 0)
//   err_underflow sticky flag: a retire hit a counter that was already zero

module rf_scoreboard #(
  parameter int NREGS  = 16,
  parameter int CNT_W  = 2,
  parameter int PC_IDX = 15
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [3:0]        rf_rs1,
  input  logic [3:0]        rf_rs2,
  input  logic [3:0]        rf_rs3,
  input  logic [2:0]        rs_used,
  input  logic [3:0]        rf_ws1,
  input  logic [3:0]        rf_ws2,
  input  logic              rf_we1,
  input  logic              rf_we2,
  input  logic              wb_we1,
  input  logic [3:0]        wb_ws1,
  input  logic              wb_we2,
  input  logic [3:0]        wb_ws2,
  input  logic              flush,
  output logic [NREGS-1:0]  pending_mask,
  output logic              err_underflow
);

  localparam int IDX_W = 4;
  localparam int SUM_W = CNT_W + 2;
  // Largest count a register may hold, widened to the arithmetic width.
  localparam logic [SUM_W-1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};
  localparam logic [IDX_W-1:0] PC_SEL  = IDX_W'(PC_IDX);

  // Counts how many of two (enable, index) pairs select the target register.
  function automatic logic [1:0] hit_count(
    input logic             en_a,
    input logic [IDX_W-1:0] idx_a,
    input logic             en_b,
    input logic [IDX_W-1:0] idx_b,
    input logic [IDX_W-1:0] target
  );
    hit_count = {1'b0, en_a && (idx_a == target)}
              + {1'b0, en_b && (idx_b == target)};
  endfunction

  // Zero-extends a 0..2 increment or decrement to the arithmetic width.
  function automatic logic [SUM_W-1:0] widen2(input logic [1:0] v);
    widen2 = {{CNT_W{1'b0}}, v};
  endfunction

  logic [CNT_W-1:0] count_r [NREGS];
  logic [NREGS-1:0] pending_mask_r;
  logic             err_underflow_r;

  logic [IDX_W-1:0] src_idx_s [3];
  logic [1:0]       req_inc_s [NREGS];
  logic [1:0]       inc_s     [NREGS];
  logic [1:0]       dec_s     [NREGS];
  logic [CNT_W-1:0] next_cnt_s [NREGS];
  logic [NREGS-1:0] next_mask_s;
  logic             raw_hazard_s;
  logic             sat_hazard_s;
  logic             ready_s;
  logic             issue_s;
  logic             underflow_s;

  // Collects the three source indices so the RAW check can loop over them.
  always_comb begin
    src_idx_s[0] = rf_rs1;
    src_idx_s[1] = rf_rs2;
    src_idx_s[2] = rf_rs3;
  end

  // RAW hazard: a used, non-PC source register has an outstanding write.
  always_comb begin
    raw_hazard_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      raw_hazard_s = raw_hazard_s
                   | (rs_used[i]
                      && (src_idx_s[i] != PC_SEL)
                      && (count_r[src_idx_s[i]] != '0));
    end
  end

  // Requested increments and retire decrements per register. Both are
  // computed without looking at issue, which keeps the saturation check
  // free of a loop back through dec_ready. The PC register is never
  // tracked, so it gets no increment and no decrement.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      if (r == PC_IDX) begin
        req_inc_s[r] = 2'b00;
        dec_s[r]     = 2'b00;
      end else begin
        req_inc_s[r] = hit_count(rf_we1, rf_ws1, rf_we2, rf_ws2, IDX_W'(r));
        dec_s[r]     = hit_count(wb_we1, wb_ws1, wb_we2, wb_ws2, IDX_W'(r));
      end
    end
  end

  // Saturation hazard: issuing would push some destination past CNT_MAX.
  // Retires in this cycle are deliberately not credited here.
  always_comb begin
    sat_hazard_s = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      sat_hazard_s = sat_hazard_s
                   | (({2'b00, count_r[r]} + widen2(req_inc_s[r])) > CNT_MAX);
    end
  end

  // Stall decision and the qualified issue strobe.
  always_comb begin
    ready_s = ~raw_hazard_s & ~sat_hazard_s;
    issue_s = dec_valid & ready_s & ~flush;
  end

  // Next counter values. A retire that would drive a counter below zero
  // clamps the counter to zero and raises the underflow flag.
  always_comb begin
    underflow_s = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      logic [SUM_W-1:0] sum_v;
      inc_s[r] = issue_s ? req_inc_s[r] : 2'b00;
      sum_v    = {2'b00, count_r[r]} + widen2(inc_s[r]);
      if (sum_v < widen2(dec_s[r])) begin
        next_cnt_s[r] = '0;
        underflow_s   = 1'b1;
      end else begin
        next_cnt_s[r] = CNT_W'(sum_v - widen2(dec_s[r]));
      end
      next_mask_s[r] = (next_cnt_s[r] != '0);
    end
  end

  // State update: reset wins over flush, and flush wins over normal tracking.
  // A flush does not clear the sticky underflow flag.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      for (int r = 0; r < NREGS; r++) begin
        count_r[r] <= '0;
      end
      pending_mask_r  <= '0;
      err_underflow_r <= 1'b0;
    end else if (flush) begin
      for (int r = 0; r < NREGS; r++) begin
        count_r[r] <= '0;
      end
      pending_mask_r  <= '0;
      err_underflow_r <= err_underflow_r;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        count_r[r] <= next_cnt_s[r];
      end
      pending_mask_r  <= next_mask_s;
      err_underflow_r <= err_underflow_r | underflow_s;
    end
  end

  assign dec_ready     = ready_s;
  assign pending_mask  = pending_mask_r;
  assign err_underflow = err_underflow_r;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard. It runs a set of directed
// scenarios, then a randomized phase. Expected values come from a
// per-register integer counter model kept in this bench.
module tb_rf_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b, dec_valid, dec_ready;
  logic [3:0]  rf_rs1, rf_rs2, rf_rs3;
  logic [2:0]  rs_used;
  logic [3:0]  rf_ws1, rf_ws2;
  logic        rf_we1, rf_we2;
  logic        wb_we1, wb_we2;
  logic [3:0]  wb_ws1, wb_ws2;
  logic        flush;
  logic [15:0] pending_mask;
  logic        err_underflow;

  rf_scoreboard dut (
    .clk(clk), .rst_b(rst_b), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rs3(rf_rs3), .rs_used(rs_used),
    .rf_ws1(rf_ws1), .rf_ws2(rf_ws2), .rf_we1(rf_we1), .rf_we2(rf_we2),
    .wb_we1(wb_we1), .wb_ws1(wb_ws1), .wb_we2(wb_we2), .wb_ws2(wb_ws2),
    .flush(flush), .pending_mask(pending_mask), .err_underflow(err_underflow)
  );

  int   cnt [16];
  bit   err_m;
  int   checks = 0;
  int   failures = 0;
  logic rdy_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decode may issue unless a used non-PC source has pending writes, or the
  // requested writes would push some register above 3 in-flight writes.
  function automatic bit model_ready();
    int req [16];
    int srcs [3];
    bit ok = 1'b1;
    srcs[0] = int'(rf_rs1); srcs[1] = int'(rf_rs2); srcs[2] = int'(rf_rs3);
    for (int r = 0; r < 16; r++) req[r] = 0;
    for (int i = 0; i < 3; i++)
      if (rs_used[i] && srcs[i] != 15 && cnt[srcs[i]] != 0) ok = 1'b0;
    if (rf_we1 && rf_ws1 != 4'd15) req[rf_ws1] += 1;
    if (rf_we2 && rf_ws2 != 4'd15) req[rf_ws2] += 1;
    for (int r = 0; r < 16; r++)
      if (cnt[r] + req[r] > 3) ok = 1'b0;
    return ok;
  endfunction

  task automatic idle();
    rst_b = 1'b1; dec_valid = 1'b0; flush = 1'b0;
    rf_rs1 = 4'd0; rf_rs2 = 4'd0; rf_rs3 = 4'd0; rs_used = 3'b000;
    rf_ws1 = 4'd0; rf_ws2 = 4'd0; rf_we1 = 1'b0; rf_we2 = 1'b0;
    wb_we1 = 1'b0; wb_ws1 = 4'd0; wb_we2 = 1'b0; wb_ws2 = 4'd0;
  endtask

  // One clock: check dec_ready mid-cycle, advance the model at the edge,
  // then check the registered outputs just after the edge.
  task automatic cycle();
    bit          exp_rdy;
    bit          issue;
    int          inc, dec;
    logic [15:0] exp_mask;
    exp_rdy = model_ready();
    @(negedge clk);
    rdy_seen = dec_ready;
    if (rst_b) chk("dec_ready", 32'(dec_ready), 32'(exp_rdy));
    @(posedge clk);
    if (!rst_b) begin
      for (int r = 0; r < 16; r++) cnt[r] = 0;
      err_m = 1'b0;
    end else if (flush) begin
      for (int r = 0; r < 16; r++) cnt[r] = 0;
    end else begin
      issue = dec_valid && exp_rdy;
      for (int r = 0; r < 15; r++) begin
        inc = 0; dec = 0;
        if (issue && rf_we1 && rf_ws1 == 4'(r)) inc++;
        if (issue && rf_we2 && rf_ws2 == 4'(r)) inc++;
        if (wb_we1 && wb_ws1 == 4'(r)) dec++;
        if (wb_we2 && wb_ws2 == 4'(r)) dec++;
        if (cnt[r] + inc < dec) begin
          cnt[r] = 0;
          err_m = 1'b1;
        end else begin
          cnt[r] = cnt[r] + inc - dec;
        end
      end
    end
    #1;
    for (int r = 0; r < 16; r++) exp_mask[r] = (cnt[r] != 0);
    chk("pending_mask", 32'(pending_mask), 32'(exp_mask));
    chk("err_underflow", 32'(err_underflow), 32'(err_m));
  endtask

  function automatic logic [3:0] pick();
    int k = int'($urandom_range(0, 6));
    return (k == 6) ? 4'd15 : 4'(k);
  endfunction

  initial begin
    for (int r = 0; r < 16; r++) cnt[r] = 0;
    err_m = 1'b0;
    idle();
    rst_b = 1'b0;
    @(posedge clk); #1;

    // Reset held low for two cycles, then released.
    cycle(); cycle();
    idle(); cycle();
    chk("reset_ready", 32'(rdy_seen), 32'd1);
    chk("reset_mask", 32'(pending_mask), 32'd0);
    chk("reset_err", 32'(err_underflow), 32'd0);

    // RAW stall on r3; a retire is not bypassed into dec_ready.
    idle(); dec_valid = 1'b1; rf_we1 = 1'b1; rf_ws1 = 4'd3; cycle();
    chk("r3_pending", 32'(pending_mask[3]), 32'd1);
    idle(); rf_rs1 = 4'd3; rs_used = 3'b001; cycle();
    chk("raw_stall", 32'(rdy_seen), 32'd0);
    idle(); rf_rs1 = 4'd3; rs_used = 3'b001; wb_we1 = 1'b1; wb_ws1 = 4'd3; cycle();
    chk("retire_no_bypass", 32'(rdy_seen), 32'd0);
    chk("r3_cleared", 32'(pending_mask[3]), 32'd0);
    idle(); rf_rs1 = 4'd3; rs_used = 3'b001; cycle();
    chk("raw_released", 32'(rdy_seen), 32'd1);

    // A same-cycle issue and retire on r5 cancel each other.
    idle(); dec_valid = 1'b1; rf_we1 = 1'b1; rf_ws1 = 4'd5; cycle();
    idle(); dec_valid = 1'b1; rf_we1 = 1'b1; rf_ws1 = 4'd5; wb_we1 = 1'b1; wb_ws1 = 4'd5; cycle();
    chk("net_zero_r5", 32'(pending_mask[5]), 32'd1);
    idle(); wb_we1 = 1'b1; wb_ws1 = 4'd5; cycle();
    chk("r5_count_was_1", 32'(pending_mask[5]), 32'd0);
    chk("r5_no_underflow", 32'(err_underflow), 32'd0);

    // Saturation of the r7 counter.
    idle(); dec_valid = 1'b1; rf_we1 = 1'b1; rf_we2 = 1'b1; rf_ws1 = 4'd7; rf_ws2 = 4'd7; cycle();
    idle(); dec_valid = 1'b1; rf_we1 = 1'b1; rf_we2 = 1'b1; rf_ws1 = 4'd7; rf_ws2 = 4'd7; cycle();
    chk("sat_2plus2", 32'(rdy_seen), 32'd0);
    idle(); dec_valid = 1'b1; rf_we1 = 1'b1; rf_ws1 = 4'd7; cycle();
    chk("sat_2plus1_ok", 32'(rdy_seen), 32'd1);
    idle(); dec_valid = 1'b1; rf_we2 = 1'b1; rf_ws2 = 4'd7; cycle();
    chk("sat_at_3", 32'(rdy_seen), 32'd0);
    idle(); wb_we1 = 1'b1; wb_we2 = 1'b1; wb_ws1 = 4'd7; wb_ws2 = 4'd7; cycle();
    idle(); wb_we1 = 1'b1; wb_ws1 = 4'd7; cycle();
    chk("r7_drained", 32'(pending_mask[7]), 32'd0);
    chk("r7_no_underflow", 32'(err_underflow), 32'd0);

    // The PC register is neither tracked nor stalled on.
    idle(); dec_valid = 1'b1; rf_we1 = 1'b1; rf_ws1 = 4'd15; rf_rs1 = 4'd15; rs_used = 3'b001; cycle();
    chk("pc_ready", 32'(rdy_seen), 32'd1);
    chk("pc_not_pending", 32'(pending_mask), 32'd0);

    // Randomized traffic checked against the model.
    for (int n = 0; n < 400; n++) begin
      idle();
      dec_valid = 1'($urandom_range(0, 1));
      rf_rs1 = pick(); rf_rs2 = pick(); rf_rs3 = pick();
      rs_used = 3'($urandom_range(0, 7));
      rf_ws1 = pick(); rf_ws2 = pick();
      rf_we1 = 1'($urandom_range(0, 1)); rf_we2 = 1'($urandom_range(0, 1));
      wb_ws1 = pick(); wb_ws2 = pick();
      wb_we1 = (cnt[wb_ws1] > 0) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 29) == 0);
      wb_we2 = (cnt[wb_ws2] > 0) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 29) == 0);
      flush = 1'($urandom_range(0, 24) == 0);
      cycle();
    end

    // Reset clears everything, including the sticky flag.
    idle(); rst_b = 1'b0; cycle();
    idle(); cycle();
    chk("rereset_err", 32'(err_underflow), 32'd0);
    chk("rereset_mask", 32'(pending_mask), 32'd0);

    // A flush drops the same-cycle issue and keeps the sticky underflow flag.
    idle(); dec_valid = 1'b1; rf_we1 = 1'b1; rf_ws1 = 4'd2; rf_we2 = 1'b1; rf_ws2 = 4'd9; cycle();
    chk("r2_r9_pending", 32'(pending_mask), 32'h0204);
    idle(); flush = 1'b1; dec_valid = 1'b1; rf_we1 = 1'b1; rf_ws1 = 4'd4; cycle();
    chk("flush_clears", 32'(pending_mask), 32'd0);
    idle(); wb_we1 = 1'b1; wb_ws1 = 4'd2; cycle();
    chk("underflow_set", 32'(err_underflow), 32'd1);
    idle(); flush = 1'b1; cycle();
    idle(); cycle();
    chk("underflow_sticky", 32'(err_underflow), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
